// File: rtl/conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_ctrl
// Description : Kernel-sweep sequencer. On s_init it visits every output
//               window position (ox inner, oy outer) and, for each window,
//               every kernel element (kx inner, ky outer). For each element
//               it issues an exec strobe with input-buffer address ia and
//               weight address wa. Each window is framed with k_init/k_fin,
//               and s_fin is pulsed once the sweep is complete. out_busy
//               stalls only the first element of a window.
// Ports       : clk, rst (async, active-low)
//               s_init / s_fin      : sweep start pulse / sweep done pulse
//               out_busy            : output-side back-pressure
//               k_init, k_fin, exec : window framing and MAC strobe
//               ia [AW], wa [WW]    : input-buffer and weight addresses
//               kw, kh [KW]         : kernel width/height minus 1
//               ow, oh [DW]         : output width/height minus 1
//               iw [DW]             : input row width
// Revision    : 1.0 - initial release
// ============================================================================
module conv_ctrl #(
    parameter int AW = 12,
    parameter int WW = 10,
    parameter int DW = 6,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_init,
    output logic          s_fin,
    input  logic          out_busy,
    output logic          k_init,
    output logic          k_fin,
    output logic          exec,
    output logic [AW-1:0] ia,
    output logic [WW-1:0] wa,
    input  logic [KW-1:0] kw,
    input  logic [KW-1:0] kh,
    input  logic [DW-1:0] ow,
    input  logic [DW-1:0] oh,
    input  logic [DW-1:0] iw
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    // Configuration captured while idle so the sweep sees a consistent set.
    logic [KW-1:0] r_kw;
    logic [KW-1:0] r_kh;
    logic [DW-1:0] r_ow;
    logic [DW-1:0] r_oh;
    logic [DW-1:0] r_iw;

    logic [KW-1:0] r_kx;
    logic [KW-1:0] r_ky;
    logic [DW-1:0] r_ox;
    logic [DW-1:0] r_oy;
    logic [AW-1:0] r_row_base;  // address of (row, column 0) of the current kernel row
    logic [AW-1:0] r_win_base;  // address of the current window's top-left element
    logic [AW-1:0] r_oy_base;   // oy * iw, kept incrementally
    logic [WW-1:0] r_wa;

    logic          w_first;
    logic          w_kx_wrap;
    logic          w_ky_wrap;
    logic          w_ox_wrap;
    logic          w_oy_wrap;
    logic [AW-1:0] w_iw_ext;

    assign w_first   = (r_kx == '0) && (r_ky == '0);
    assign w_kx_wrap = (r_kx == r_kw);
    assign w_ky_wrap = (r_ky == r_kh);
    assign w_ox_wrap = (r_ox == r_ow);
    assign w_oy_wrap = (r_oy == r_oh);
    assign w_iw_ext  = AW'(r_iw);

    assign ia = r_row_base + AW'(r_kx);
    assign wa = r_wa;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes. out_busy only matters at the first element
    // of a window; it is the sole combinational input-to-output path.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        exec        = 1'b0;
        k_init      = 1'b0;
        k_fin       = 1'b0;
        s_fin       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_init) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                exec   = !(w_first && out_busy);
                k_init = exec && w_first;
                k_fin  = exec && w_kx_wrap && w_ky_wrap;
                if (k_fin && w_ox_wrap && w_oy_wrap) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                s_fin       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and address bases. Everything holds when exec is low.
    // Counters return to zero after the last window so the idle state
    // always presents ia = wa = 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kw       <= '0;
            r_kh       <= '0;
            r_ow       <= '0;
            r_oh       <= '0;
            r_iw       <= '0;
            r_kx       <= '0;
            r_ky       <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_row_base <= '0;
            r_win_base <= '0;
            r_oy_base  <= '0;
            r_wa       <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_kw <= kw;
                r_kh <= kh;
                r_ow <= ow;
                r_oh <= oh;
                r_iw <= iw;
                if (s_init) begin
                    r_kx       <= '0;
                    r_ky       <= '0;
                    r_ox       <= '0;
                    r_oy       <= '0;
                    r_row_base <= '0;
                    r_win_base <= '0;
                    r_oy_base  <= '0;
                    r_wa       <= '0;
                end
            end
            if (exec) begin
                r_wa <= k_fin ? '0 : r_wa + 1'b1;
                if (!w_kx_wrap) begin
                    r_kx <= r_kx + 1'b1;
                end else begin
                    r_kx <= '0;
                    if (!w_ky_wrap) begin
                        r_ky       <= r_ky + 1'b1;
                        r_row_base <= r_row_base + w_iw_ext;
                    end else begin
                        r_ky <= '0;
                        if (w_ox_wrap && w_oy_wrap) begin
                            r_ox       <= '0;
                            r_oy       <= '0;
                            r_row_base <= '0;
                            r_win_base <= '0;
                            r_oy_base  <= '0;
                        end else if (!w_ox_wrap) begin
                            r_ox       <= r_ox + 1'b1;
                            r_win_base <= r_win_base + 1'b1;
                            r_row_base <= r_win_base + 1'b1;
                        end else begin
                            r_ox       <= '0;
                            r_oy       <= r_oy + 1'b1;
                            r_oy_base  <= r_oy_base + w_iw_ext;
                            r_win_base <= r_oy_base + w_iw_ext;
                            r_row_base <= r_oy_base + w_iw_ext;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_ctrl
// Description : Directed testbench for conv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_ctrl;

    localparam int AW = 12;
    localparam int WW = 10;
    localparam int DW = 6;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_init;
    logic          s_fin;
    logic          out_busy;
    logic          k_init;
    logic          k_fin;
    logic          exec;
    logic [AW-1:0] ia;
    logic [WW-1:0] wa;
    logic [KW-1:0] kw;
    logic [KW-1:0] kh;
    logic [DW-1:0] ow;
    logic [DW-1:0] oh;
    logic [DW-1:0] iw;

    int checks = 0;
    int errors = 0;

    // Hand-computed ia sequence for kw=kh=1, ow=oh=1, iw=3.
    int ia_tab [16] = '{0, 1, 3, 4,  1, 2, 4, 5,  3, 4, 6, 7,  4, 5, 7, 8};

    conv_ctrl #(.AW(AW), .WW(WW), .DW(DW), .KW(KW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_init   (s_init),
        .s_fin    (s_fin),
        .out_busy (out_busy),
        .k_init   (k_init),
        .k_fin    (k_fin),
        .exec     (exec),
        .ia       (ia),
        .wa       (wa),
        .kw       (kw),
        .kh       (kh),
        .ow       (ow),
        .oh       (oh),
        .iw       (iw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input logic e_exec, input int e_ia,
                           input int e_wa, input logic e_ki, input logic e_kf, input logic e_sf);
        chk($sformatf("%s c%0d exec", tag, c),   32'(exec),   32'(e_exec));
        chk($sformatf("%s c%0d ia", tag, c),     32'(ia),     32'(e_ia));
        chk($sformatf("%s c%0d wa", tag, c),     32'(wa),     32'(e_wa));
        chk($sformatf("%s c%0d k_init", tag, c), 32'(k_init), 32'(e_ki));
        chk($sformatf("%s c%0d k_fin", tag, c),  32'(k_fin),  32'(e_kf));
        chk($sformatf("%s c%0d s_fin", tag, c),  32'(s_fin),  32'(e_sf));
    endtask

    // Basic 2x2 sweep with optional busy window, expected stall window,
    // a second s_init at rs_c, and an asynchronous reset in cycle abort_c.
    // Cycle 0 is the s_init cycle.
    task automatic sweep(input string tag, input int b_lo, input int b_hi, input int s_lo,
                         input int s_hi, input int rs_c, input int abort_c);
        int stall_n;
        int e;
        stall_n = (s_hi >= s_lo) ? (s_hi - s_lo + 1) : 0;
        kw = 4'd1; kh = 4'd1; ow = 6'd1; oh = 6'd1; iw = 6'd3;
        for (int c = 0; c <= 19 + stall_n; c++) begin
            s_init   = (c == 0) || (c == rs_c);
            out_busy = (c >= b_lo) && (c <= b_hi);
            @(negedge clk);
            if (c >= s_lo && c <= s_hi) begin
                chk_all(tag, c, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
            end else begin
                e = c - 1 - ((c > s_hi && stall_n > 0) ? stall_n : 0);
                if (e >= 0 && e < 16)
                    chk_all(tag, c, 1'b1, ia_tab[e], e % 4, (e % 4) == 0, (e % 4) == 3, 1'b0);
                else
                    chk_all(tag, c, 1'b0, 0, 0, 1'b0, 1'b0, c == 17 + stall_n);
            end
            if (c == abort_c) begin
                #2 rst = 1'b0;
                #1 chk_all({tag, " rst"}, c, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    chk($sformatf("%s held-reset s_fin %0d", tag, k), 32'(s_fin), 32'd0);
                end
                @(posedge clk);
                #1 rst = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        s_init   = 1'b0;
        out_busy = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        s_init   = 1'b0;
        out_busy = 1'b0;
        kw = 4'd1; kh = 4'd1; ow = 6'd1; oh = 6'd1; iw = 6'd3;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        sweep("basic",    100, 99, 100, 99, -1, -1);
        sweep("stall",      5,  7,   5,  7, -1, -1);
        sweep("midbusy",    2,  3, 100, 99, -1, -1);
        sweep("restart",  100, 99, 100, 99,  6, -1);

        // 1x1 kernel, three windows in one row.
        kw = 4'd0; kh = 4'd0; ow = 6'd2; oh = 6'd0; iw = 6'd5;
        for (int c = 0; c <= 5; c++) begin
            s_init = (c == 0);
            @(negedge clk);
            if (c >= 1 && c <= 3)
                chk_all("k1x1", c, 1'b1, c - 1, 0, 1'b1, 1'b1, 1'b0);
            else
                chk_all("k1x1", c, 1'b0, 0, 0, 1'b0, 1'b0, c == 4);
            @(posedge clk);
            #1;
        end
        s_init = 1'b0;

        sweep("abort",    100, 99, 100, 99, -1, 7);
        sweep("after",    100, 99, 100, 99, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_ctrl.md
Name: conv_ctrl

Overview:
- Kernel-sweep sequencer between the batch controller and the output controller.
- On `s_init` (source buffer loaded), walks every output window position and, for each, every kernel element.
- Emits an `exec` strobe with input-buffer address `ia` and weight address `wa` for each element; frames each window with `k_init`/`k_fin` for the output controller.
- Returns `s_fin` to the batch controller when the sweep completes; honours `out_busy` back-pressure at window boundaries.

Parameters:
- AW, 12, input-buffer address width (`ia`).
- WW, 10, weight address width (`wa`).
- DW, 6, width of output-dimension and row-width configuration.
- KW, 4, width of kernel-dimension configuration.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- s_init  in  1  one-cycle pulse: start a sweep.
- s_fin  out  1  one-cycle pulse: sweep complete.
- out_busy  in  1  output controller draining; blocks the start of a new window.
- k_init  out  1  first kernel element of a window (qualified by `exec`).
- k_fin  out  1  last kernel element of a window (qualified by `exec`).
- exec  out  1  MAC-enable strobe; `ia`/`wa` valid.
- ia  out  AW  input-buffer read address.
- wa  out  WW  weight read address.
- kw  in  KW  kernel width minus 1.
- kh  in  KW  kernel height minus 1.
- ow  in  DW  output width minus 1.
- oh  in  DW  output height minus 1.
- iw  in  DW  input row width (not minus 1).

Behaviour:
- States: IDLE, RUN, FIN. Reset state is IDLE.
- Reset values: all counters and bases 0; `exec`, `k_init`, `k_fin`, `s_fin`, `ia`, `wa` all 0.
- Config inputs are sampled only while in IDLE and held stable by the system during RUN.
- Counters:
  - Inner loops: `kx` 0..kw, `ky` 0..kh.
  - Outer loops: `ox` 0..ow, `oy` 0..oh.
  - Order, innermost first: `kx`, `ky`, `ox`, `oy`.
- IDLE:
  - `s_init`=1 → RUN next cycle, with all counters 0, `win_base`=0, `row_base`=0, `wa`=0.
  - `s_init` at cycle t gives the first `exec` at t+1.
- RUN:
  - `exec` = !(`kx`==0 & `ky`==0 & `out_busy`). This is the only combinational input→output path.
  - When `exec`=0, every counter, base, `ia` and `wa` holds.
  - `out_busy` is ignored at every kernel element other than the first.
  - `k_init` = `exec` & `kx`==0 & `ky`==0.
  - `k_fin` = `exec` & `kx`==kw & `ky`==kh.
  - When kw=kh=0, `k_init` and `k_fin` assert in the same cycle.
- Addressing, no multipliers:
  - `ia` = `row_base` + `kx`.
  - `kx` wrap: `row_base` += `iw`.
  - `ky` wrap: `win_base` += 1 (or, on `ox` wrap, `win_base` = `oy_base` + `iw`, where `oy_base` tracks `oy`*`iw`); then `row_base` = new `win_base`.
  - Net result: `ia` = (`oy`+`ky`)*`iw` + `ox` + `kx`, mod 2^AW.
  - `wa` increments on each `exec`; resets to 0 at `k_fin` (= `ky`*(kw+1)+`kx`), mod 2^WW.
- Window advance:
  - On a `k_fin` cycle that is not the last window, the next window starts the following cycle (back-to-back) unless `out_busy`=1, which stalls it.
- Last window:
  - On `k_fin` with `ox`==ow & `oy`==oh → FIN.
- FIN:
  - `s_fin`=1 for exactly one cycle, `exec`=0, then IDLE.
  - `s_fin` is asserted in the cycle after the last `k_fin`.
- `s_init` in RUN or FIN is ignored.
- `rst` low at any time: immediate return to reset values; no `s_fin` is emitted for an aborted sweep.
- No wrap detection: if config makes the addresses exceed 2^AW or 2^WW, they wrap silently.

Test Plan:
- Basic 2x2 sweep. Config kw=kh=1, ow=oh=1, iw=3; `out_busy`=0; `s_init` at cycle 0.
  - `exec` high cycles 1..16.
  - `ia` = 0,1,3,4 | 1,2,4,5 | 3,4,6,7 | 4,5,7,8.
  - `wa` = 0,1,2,3 repeating.
  - `k_init` at cycles 1,5,9,13; `k_fin` at 4,8,12,16; `s_fin` only at cycle 17.
- Stall at window start. Same config; `out_busy`=1 during cycles 5..7.
  - `exec`=0 for cycles 5..7, with `ia`=1, `wa`=0 held.
  - `k_init` at cycle 8; last `k_fin` at 19; `s_fin` at 20.
- Busy mid-kernel ignored. `out_busy`=1 during cycles 2..3.
  - No stall; sequence identical to the basic sweep.
- 1x1 kernel. Config kw=kh=0, ow=2, oh=0, iw=5.
  - `ia` = 0,1,2; `wa`=0 throughout.
  - `k_init` and `k_fin` coincide at cycles 1,2,3; `s_fin` at 4.
- Ignored restart. Basic config; second `s_init` at cycle 6.
  - No effect: the 16-cycle sequence completes unchanged and `s_fin` asserts once.
- Reset mid-run. Assert `rst` low asynchronously at cycle 7.5.
  - All outputs 0 immediately; no `s_fin`.
  - A fresh `s_init` after release restarts from `ia`=0.
